// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encoding, PC defaults and a word-align helper.
package pc_fetch_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_FULL = 2'd2;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_STEP_DEF  = 32'd4;

   // Instructions are word-sized, so redirect targets drop their byte offset.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect arbiter: trap beats branch, target forced to a word boundary.
module pc_redirect_sel
   import pc_fetch_ctrl_pkg::*;
(
   input  logic        trap_valid_i,
   input  logic [31:0] trap_target_i,
   input  logic        br_valid_i,
   input  logic [31:0] br_target_i,
   output logic        redir_o,
   output logic [31:0] tgt_o
);

   logic [31:0] raw_tgt;

   assign raw_tgt = trap_valid_i ? trap_target_i : br_target_i;
   assign tgt_o   = word_align(raw_tgt);
   assign redir_o = trap_valid_i | br_valid_i;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and single-outstanding instruction fetch with a one-entry IF/ID slot.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEF
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        trap_valid,
   input  logic [31:0] trap_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_inst,
   output logic [31:0] pc
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        kill_q, kill_d;
   logic        fvalid_q, fvalid_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] finst_q, finst_d;

   logic        redir;
   logic [31:0] tgt;

   pc_redirect_sel u_redirect_sel (
      .trap_valid_i  (trap_valid),
      .trap_target_i (trap_target),
      .br_valid_i    (br_valid),
      .br_target_i   (br_target),
      .redir_o       (redir),
      .tgt_o         (tgt)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      kill_d    = kill_q;
      fvalid_d  = fvalid_q;
      fpc_d     = fpc_q;
      finst_d   = finst_q;

      case (state_q)
         ST_IDLE: begin
            if (redir) pc_d = tgt;
            state_d = ST_REQ;
         end
         ST_REQ: begin
            // While a request is outstanding pc must not move; a redirect is parked
            // in pend_pc and the stale response is dropped when it finally arrives.
            if (imem_ack && (kill_q || redir)) begin
               pc_d   = redir ? tgt : pend_pc_q;
               kill_d = 1'b0;
            end else if (imem_ack) begin
               finst_d  = imem_rdata;
               fpc_d    = pc_q;
               fvalid_d = 1'b1;
               pc_d     = pc_q + PC_STEP;
               state_d  = ST_FULL;
            end else if (redir) begin
               pend_pc_d = tgt;
               kill_d    = 1'b1;
            end
         end
         ST_FULL: begin
            if (redir) begin
               fvalid_d = 1'b0;
               pc_d     = tgt;
               state_d  = ST_REQ;
            end else if (!stall) begin
               fvalid_d = 1'b0;
               state_d  = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         pend_pc_q <= 32'h0;
         kill_q    <= 1'b0;
         fvalid_q  <= 1'b0;
         fpc_q     <= 32'h0;
         finst_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         kill_q    <= kill_d;
         fvalid_q  <= fvalid_d;
         fpc_q     <= fpc_d;
         finst_q   <= finst_d;
      end
   end

   assign imem_req    = (state_q == ST_REQ);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign fetch_valid = fvalid_q;
   assign fetch_pc    = fpc_q;
   assign fetch_inst  = finst_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; accepted fetches are scoreboarded against a memory model.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        br_valid;
   logic [31:0] br_target;
   logic        trap_valid;
   logic [31:0] trap_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic [31:0] pc;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_t;

   fetch_t exp_q[$];
   int     total = 0;
   int     bad   = 0;
   logic   prev_valid = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .trap_valid  (trap_valid),
      .trap_target (trap_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .fetch_inst  (fetch_inst),
      .pc          (pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; a slot that just became valid must match the scoreboard head.
   task automatic tick();
      fetch_t e;
      @(posedge clk);
      #1;
      if (fetch_valid && !prev_valid) begin
         chk("sb_slot_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_fetch_pc", fetch_pc, e.pc);
            chk("sb_fetch_inst", fetch_inst, e.inst);
            $display("slot pc=%h inst=%h", fetch_pc, fetch_inst);
         end
      end
      prev_valid = fetch_valid;
   endtask

   // Respond to the current request for one cycle; keep=1 means the word must reach the slot.
   task automatic ack_cycle(input logic keep);
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      if (keep) exp_q.push_back('{pc: imem_addr, inst: mem_word(imem_addr)});
      $display("ack addr=%h keep=%0d", imem_addr, keep);
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = 32'h0;
      trap_valid = 1'b0; trap_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;

      tick(); tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_fpc", fetch_pc, 32'h0);
      chk("rst_finst", fetch_inst, 32'h0);

      // Zero-wait memory streaming
      rst = 1'b0;
      tick();
      chk("seq_req0", {31'd0, imem_req}, 32'd1);
      chk("seq_addr0", imem_addr, 32'h0);
      ack_cycle(1'b1);
      chk("seq_full_req", {31'd0, imem_req}, 32'd0);
      chk("seq_fv0", {31'd0, fetch_valid}, 32'd1);
      tick();
      chk("seq_addr4", imem_addr, 32'h4);
      chk("seq_fv_gap", {31'd0, fetch_valid}, 32'd0);
      ack_cycle(1'b1);
      chk("seq_fpc4", fetch_pc, 32'h4);

      // Stall holds the slot for three cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_fv", {31'd0, fetch_valid}, 32'd1);
         chk("stall_fpc", fetch_pc, 32'h4);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;
      tick();
      chk("stall_next_req", {31'd0, imem_req}, 32'd1);
      chk("stall_next_addr", imem_addr, 32'h8);

      // Branch while the fetch of 0x8 is outstanding
      br_valid = 1'b1; br_target = 32'h100;
      tick();
      br_valid = 1'b0;
      chk("kill_addr_stable", imem_addr, 32'h8);
      chk("kill_req", {31'd0, imem_req}, 32'd1);
      ack_cycle(1'b0);
      chk("kill_fv", {31'd0, fetch_valid}, 32'd0);
      chk("kill_next_addr", imem_addr, 32'h100);
      ack_cycle(1'b1);
      chk("br_fpc", fetch_pc, 32'h100);

      // Trap and branch together in FULL under stall
      stall = 1'b1;
      trap_valid = 1'b1; trap_target = 32'h80;
      br_valid = 1'b1; br_target = 32'h200;
      tick();
      trap_valid = 1'b0; br_valid = 1'b0; stall = 1'b0;
      chk("trap_flush_fv", {31'd0, fetch_valid}, 32'd0);
      chk("trap_addr", imem_addr, 32'h80);

      // Unaligned branch target from FULL
      ack_cycle(1'b1);
      br_valid = 1'b1; br_target = 32'h103;
      tick();
      br_valid = 1'b0;
      chk("align_addr", imem_addr, 32'h100);

      // Ack coinciding with a redirect lands on the aligned top-of-memory word
      br_valid = 1'b1; br_target = 32'hFFFF_FFFF;
      ack_cycle(1'b0);
      br_valid = 1'b0;
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      chk("top_fv", {31'd0, fetch_valid}, 32'd0);
      ack_cycle(1'b1);
      chk("wrap_pc", pc, 32'h0);
      tick();
      chk("wrap_addr", imem_addr, 32'h0);

      // Two redirects during one outstanding request: the later one wins
      br_valid = 1'b1; br_target = 32'h40;
      tick();
      br_valid = 1'b0;
      trap_valid = 1'b1; trap_target = 32'h50;
      tick();
      trap_valid = 1'b0;
      chk("latest_addr_stable", imem_addr, 32'h0);
      ack_cycle(1'b0);
      chk("latest_addr", imem_addr, 32'h50);

      // Stray ack while FULL is ignored
      ack_cycle(1'b1);
      stall = 1'b1;
      ack_cycle(1'b0);
      chk("stray_full_pc", pc, 32'h54);
      chk("stray_full_fpc", fetch_pc, 32'h50);
      chk("stray_full_req", {31'd0, imem_req}, 32'd0);
      stall = 1'b0;
      tick();
      chk("pre_rst_addr", imem_addr, 32'h54);

      // Asynchronous reset with a request outstanding
      rst = 1'b1;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_pc", pc, 32'h0);
      chk("arst_fpc", fetch_pc, 32'h0);
      chk("arst_finst", fetch_inst, 32'h0);
      tick();
      rst = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      tick();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      chk("idle_ack_fv", {31'd0, fetch_valid}, 32'd0);
      chk("rel_req", {31'd0, imem_req}, 32'd1);
      chk("rel_addr", imem_addr, 32'h0);
      ack_cycle(1'b1);
      tick();

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
